wb_host_master: RTL and testbench
=================================

WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum wbm_stb_o-high cycles waiting for ack before error; legal range 1..65535.
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have ports cmd_we (input, 1) and cmd_sel (input, 4): write flag; byte selects.
REQ-007 SHALL have ports cmd_adr (input, 32) and cmd_dat (input, 32): byte address; write data.
REQ-008 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): response handshake.
REQ-009 SHALL have ports rsp_dat (output, 32) and rsp_err (output, 1): read data; timeout flag.
REQ-010 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o (output, 1 each): Wishbone classic control.
REQ-011 SHALL have ports wbm_sel_o (output, 4), wbm_adr_o (output, 32), wbm_dat_o (output, 32).
REQ-012 SHALL have ports wbm_dat_i (input, 32), wbm_ack_i (input, 1): slave read data; acknowledge.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE, BUS, RESP; all outputs driven from registers or state decode only (no input-to-output combinational path).
REQ-015 In IDLE, cmd_ready SHALL be 1; in BUS and RESP, cmd_ready SHALL be 0.
REQ-016 On edge with cmd_valid&cmd_ready: latch we/sel/adr/dat into wbm_* registers, set wbm_cyc_o=wbm_stb_o=1, clear timer, enter BUS.
REQ-017 In BUS, wbm_cyc_o, wbm_stb_o and all wbm_* address/data/select/we outputs SHALL stay constant until exit.
REQ-018 In BUS, edge with wbm_ack_i=1: rsp_dat<=wbm_dat_i for reads, 0 for writes; rsp_err<=0; cyc/stb<=0; enter RESP.
REQ-019 In BUS, edge with wbm_ack_i=0: timer increments; when timer reaches TIMEOUT_CYCLES-1 on that edge: rsp_dat<=0, rsp_err<=1, cyc/stb<=0, enter RESP.
REQ-020 Ack and timeout on the same edge: ack SHALL win (rsp_err=0).
REQ-021 Timer width SHALL be sufficient for TIMEOUT_CYCLES with no wrap; timer SHALL not count outside BUS.
REQ-022 In RESP, rsp_valid=1 with rsp_dat/rsp_err stable; on edge with rsp_ready=1 enter IDLE, rsp_valid<=0.
REQ-023 wbm_ack_i in IDLE or RESP SHALL be ignored (no state, data or error change).
REQ-024 Minimum latency: command accepted edge 0, stb high cycle 1, ack in cycle 1, rsp_valid high cycle 2; new command acceptable cycle 3 if rsp_ready held high.
REQ-025 Back-to-back: cyc/stb SHALL be low for at least one cycle between transactions.

Reset
REQ-026 wb_rst_i=1 SHALL immediately force: state IDLE, cmd_ready=0 while asserted then 1, rsp_valid=0, rsp_err=0, rsp_dat=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, busy=0, timer=0.
REQ-027 Reset during BUS or RESP SHALL abandon the transaction with no response ever produced for it.

Verification
REQ-028 Write: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave acks 2 cycles after stb -> bus outputs match, rsp_valid with rsp_err=0, rsp_dat=0.
REQ-029 Read: cmd we=0 adr=0x3000_0000, ack same cycle as stb with dat_i=0x1234_5678 -> rsp_valid on cycle 2 after accept, rsp_dat=0x1234_5678.
REQ-030 Timeout: TIMEOUT_CYCLES=4, no ack -> stb high exactly 4 cycles, then rsp_err=1, rsp_dat=0, cyc low.
REQ-031 Backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_dat held, cmd_ready=0, cmd_valid ignored; stray ack ignored.
REQ-032 Reset mid-BUS: assert wb_rst_i between edges while stb high -> cyc/stb drop asynchronously, no rsp_valid after release.
REQ-033 Ack coincident with timeout edge (TIMEOUT_CYCLES=3, ack on 3rd stb cycle) -> rsp_err=0, read data returned.

Source files
------------

// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
//
// Purpose:
//   Bridges a simple valid/ready command/response interface onto a Wishbone
//   classic single-transfer master port. One command is in flight at a time.
//   A transfer that is not acknowledged within TIMEOUT_CYCLES strobe cycles is
//   terminated by the master and reported with rsp_err=1.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of wbm_stb_o-high cycles waiting for ack
//                   (legal range 1..65535)
//
// Ports:
//   wb_clk_i, wb_rst_i      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_we/sel/adr/dat      command write flag, byte selects, address, data
//   rsp_valid/rsp_ready     response handshake
//   rsp_dat/rsp_err         read data (0 for writes/timeouts), timeout flag
//   wbm_*_o                 Wishbone master outputs (cyc, stb, we, sel, adr, dat)
//   wbm_dat_i, wbm_ack_i    Wishbone slave read data and acknowledge
//   busy                    high whenever a command is in progress
//
// Every output comes straight from a flop or from state decode; no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,

  output logic        busy
);

  // The timer only has to hold 0..TIMEOUT_CYCLES-1: the transfer is closed
  // on the edge where it would otherwise move past the last value.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          timeout_hit;

  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_dat_q;
  logic          rsp_err_q;
  logic          wbm_cyc_q;
  logic          wbm_stb_q;
  logic          wbm_we_q;
  logic [3:0]    wbm_sel_q;
  logic [31:0]   wbm_adr_q;
  logic [31:0]   wbm_dat_q;

  always_comb begin
    timer_d     = timer_q + TW'(1);
    timeout_hit = (timer_q == TIMER_LAST);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      wbm_cyc_q   <= 1'b0;
      wbm_stb_q   <= 1'b0;
      wbm_we_q    <= 1'b0;
      wbm_sel_q   <= '0;
      wbm_adr_q   <= '0;
      wbm_dat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // cmd_ready is held low through reset and rises on the first edge
          // after release, so a command is never taken while in reset.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            wbm_we_q    <= cmd_we;
            wbm_sel_q   <= cmd_sel;
            wbm_adr_q   <= cmd_adr;
            wbm_dat_q   <= cmd_dat;
            wbm_cyc_q   <= 1'b1;
            wbm_stb_q   <= 1'b1;
            timer_q     <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end

        BUS: begin
          // Ack is tested first so that an ack on the timeout edge wins.
          if (wbm_ack_i) begin
            rsp_dat_q   <= wbm_we_q ? 32'h0 : wbm_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            wbm_cyc_q   <= 1'b0;
            wbm_stb_q   <= 1'b0;
            timer_q     <= '0;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            wbm_cyc_q   <= 1'b0;
            wbm_stb_q   <= 1'b0;
            timer_q     <= '0;
            state_q     <= RESP;
          end else begin
            timer_q <= timer_d;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          wbm_cyc_q   <= 1'b0;
          wbm_stb_q   <= 1'b0;
          timer_q     <= '0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = wbm_cyc_q;
  assign wbm_stb_o = wbm_stb_q;
  assign wbm_we_o  = wbm_we_q;
  assign wbm_sel_o = wbm_sel_q;
  assign wbm_adr_o = wbm_adr_q;
  assign wbm_dat_o = wbm_dat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wb_host_master.sv
// -----------------------------------------------------------------------------
// tb_wb_host_master
//
// Two instances are driven from the same command stream: instance 0 with a
// strobe limit of 4 cycles and instance 1 with a limit of 3. Each instance has
// its own Wishbone slave stub. A cycle-level behavioural model per instance
// predicts every output; a compare process checks all of them each cycle.
// -----------------------------------------------------------------------------
module tb_wb_host_master;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_ready;

  logic        cmd_ready_w [NDUT];
  logic        rsp_valid_w [NDUT];
  logic [31:0] rsp_dat_w   [NDUT];
  logic        rsp_err_w   [NDUT];
  logic        cyc_w       [NDUT];
  logic        stb_w       [NDUT];
  logic        we_w        [NDUT];
  logic [3:0]  sel_w       [NDUT];
  logic [31:0] adr_w       [NDUT];
  logic [31:0] dato_w      [NDUT];
  logic [31:0] dati_w      [NDUT];
  logic        ack_w       [NDUT];
  logic        busy_w      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_host_master #(.TIMEOUT_CYCLES((g == 0) ? 4 : 3)) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready_w[g]),
      .cmd_we    (cmd_we),
      .cmd_sel   (cmd_sel),
      .cmd_adr   (cmd_adr),
      .cmd_dat   (cmd_dat),
      .rsp_valid (rsp_valid_w[g]),
      .rsp_ready (rsp_ready),
      .rsp_dat   (rsp_dat_w[g]),
      .rsp_err   (rsp_err_w[g]),
      .wbm_cyc_o (cyc_w[g]),
      .wbm_stb_o (stb_w[g]),
      .wbm_we_o  (we_w[g]),
      .wbm_sel_o (sel_w[g]),
      .wbm_adr_o (adr_w[g]),
      .wbm_dat_o (dato_w[g]),
      .wbm_dat_i (dati_w[g]),
      .wbm_ack_i (ack_w[g]),
      .busy      (busy_w[g])
    );
  end

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for a command, 1 = on the bus, 2 = holding a response
  int          m_phase [NDUT];
  bit          m_rdy   [NDUT];
  bit          m_we    [NDUT];
  logic [3:0]  m_sel   [NDUT];
  logic [31:0] m_adr   [NDUT];
  logic [31:0] m_dat   [NDUT];
  logic [31:0] m_rdat  [NDUT];
  bit          m_rerr  [NDUT];
  int          m_n     [NDUT];   // strobe cycles already completed
  int          dly     [NDUT];   // strobe cycle index (0-based) in which the stub acks

  int          errors = 0;
  int          checks = 0;
  bit          cmp_en = 1'b0;
  int          dly_force = -1;
  logic [31:0] rd_force = 32'h0;
  bit          stray_en = 1'b0;

  function automatic int tmo(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_phase[i] = 0;
      m_rdy[i]   = 1'b0;
      m_we[i]    = 1'b0;
      m_sel[i]   = 4'h0;
      m_adr[i]   = 32'h0;
      m_dat[i]   = 32'h0;
      m_rdat[i]  = 32'h0;
      m_rerr[i]  = 1'b0;
      m_n[i]     = 0;
    end
  endtask

  // Applies one rising edge using the inputs that were present at that edge.
  task automatic model_edge();
    for (int i = 0; i < NDUT; i++) begin
      if (m_phase[i] == 0) begin
        if (cmd_valid && m_rdy[i]) begin
          m_we[i]    = cmd_we;
          m_sel[i]   = cmd_sel;
          m_adr[i]   = cmd_adr;
          m_dat[i]   = cmd_dat;
          m_phase[i] = 1;
          m_n[i]     = 0;
          dly[i]     = (dly_force >= 0) ? dly_force : int'($urandom_range(0, tmo(i) + 1));
        end
      end else if (m_phase[i] == 1) begin
        m_n[i]++;
        if (ack_w[i]) begin
          m_rdat[i]  = m_we[i] ? 32'h0 : dati_w[i];
          m_rerr[i]  = 1'b0;
          m_phase[i] = 2;
        end else if (m_n[i] == tmo(i)) begin
          m_rdat[i]  = 32'h0;
          m_rerr[i]  = 1'b1;
          m_phase[i] = 2;
        end
      end else begin
        if (rsp_ready) m_phase[i] = 0;
      end
      m_rdy[i] = (m_phase[i] == 0);
    end
  endtask

  task automatic drive_slave();
    for (int i = 0; i < NDUT; i++) begin
      if (m_phase[i] == 1) begin
        ack_w[i]  = (m_n[i] == dly[i]);
        dati_w[i] = (dly_force >= 0) ? rd_force : $urandom();
      end else begin
        ack_w[i]  = stray_en && ($urandom_range(0, 3) == 0);
        dati_w[i] = $urandom();
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_edge();
    drive_slave();
  endtask

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input int d);
    dly_force = d;
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while (!(m_phase[0] == 0 && m_phase[1] == 0 && m_rdy[0] && m_rdy[1]) && k < 20) begin
      cycle();
      k++;
    end
    chk("drain_bound", 32'(k < 20), 32'd1);
    rsp_ready = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("cmd_ready[%0d]", i), 32'(cmd_ready_w[i]), 32'(m_rdy[i]));
        chk($sformatf("cyc[%0d]", i),       32'(cyc_w[i]),       32'(m_phase[i] == 1));
        chk($sformatf("stb[%0d]", i),       32'(stb_w[i]),       32'(m_phase[i] == 1));
        chk($sformatf("busy[%0d]", i),      32'(busy_w[i]),      32'(m_phase[i] != 0));
        chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'(m_phase[i] == 2));
        chk($sformatf("rsp_dat[%0d]", i),   rsp_dat_w[i],        m_rdat[i]);
        chk($sformatf("rsp_err[%0d]", i),   32'(rsp_err_w[i]),   32'(m_rerr[i]));
        chk($sformatf("we[%0d]", i),        32'(we_w[i]),        32'(m_we[i]));
        chk($sformatf("sel[%0d]", i),       32'(sel_w[i]),       32'(m_sel[i]));
        chk($sformatf("adr[%0d]", i),       adr_w[i],            m_adr[i]);
        chk($sformatf("dato[%0d]", i),      dato_w[i],           m_dat[i]);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt0;
    int cnt1;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = 4'h0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      ack_w[i]  = 1'b0;
      dati_w[i] = 32'h0;
    end
    model_reset();
    #1 cmp_en = 1'b1;

    // reset values, pinned to literals
    #2;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_cmd_ready", 32'(cmd_ready_w[i]), 32'd0);
      chk("rst_cyc",       32'(cyc_w[i]),       32'd0);
      chk("rst_busy",      32'(busy_w[i]),      32'd0);
      chk("rst_rsp_dat",   rsp_dat_w[i],        32'h0);
    end
    cycle();
    cycle();
    #2 rst = 1'b0;
    cycle();
    for (int i = 0; i < NDUT; i++) chk("ready_after_rst", 32'(cmd_ready_w[i]), 32'd1);

    // write, ack in the third strobe cycle
    issue(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 2);
    for (int i = 0; i < NDUT; i++) begin
      chk("wr_stb", 32'(stb_w[i]), 32'd1);
      chk("wr_adr", adr_w[i], 32'h3000_0004);
      chk("wr_dat", dato_w[i], 32'hDEAD_BEEF);
      chk("wr_we",  32'(we_w[i]), 32'd1);
      chk("wr_sel", 32'(sel_w[i]), 32'hF);
    end
    repeat (3) cycle();
    for (int i = 0; i < NDUT; i++) begin
      chk("wr_rsp_valid", 32'(rsp_valid_w[i]), 32'd1);
      chk("wr_rsp_err",   32'(rsp_err_w[i]),   32'd0);
      chk("wr_rsp_dat",   rsp_dat_w[i],        32'h0);
      chk("wr_cyc_low",   32'(cyc_w[i]),       32'd0);
    end
    drain();

    // read, ack in the first strobe cycle, minimum latency
    rd_force  = 32'h1234_5678;
    rsp_ready = 1'b1;
    issue(1'b0, 4'hF, 32'h3000_0000, 32'h0, 0);
    rsp_ready = 1'b1;
    chk("rd_stb_c1", 32'(stb_w[0]), 32'd1);
    cycle();
    chk("rd_valid_c2", 32'(rsp_valid_w[0]), 32'd1);
    chk("rd_dat_c2",   rsp_dat_w[0], 32'h1234_5678);
    chk("rd_err_c2",   32'(rsp_err_w[1]), 32'd0);
    cycle();
    chk("rd_ready_c3", 32'(cmd_ready_w[0]), 32'd1);
    chk("rd_cyc_gap",  32'(cyc_w[0]), 32'd0);
    issue(1'b0, 4'h3, 32'h3000_0008, 32'h0, 0);
    chk("b2b_stb", 32'(stb_w[1]), 32'd1);
    drain();

    // timeout: no ack at all
    rd_force = 32'hFFFF_FFFF;
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0, 100);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (stb_w[0]) cnt0++;
      if (stb_w[1]) cnt1++;
      cycle();
    end
    chk("tmo_stb_cycles0", 32'(cnt0), 32'd4);
    chk("tmo_stb_cycles1", 32'(cnt1), 32'd3);
    for (int i = 0; i < NDUT; i++) begin
      chk("tmo_err",   32'(rsp_err_w[i]),   32'd1);
      chk("tmo_dat",   rsp_dat_w[i],        32'h0);
      chk("tmo_cyc",   32'(cyc_w[i]),       32'd0);
      chk("tmo_valid", 32'(rsp_valid_w[i]), 32'd1);
    end

    // backpressure on the held timeout response, with stray acks and commands
    stray_en  = 1'b1;
    cmd_valid = 1'b1;
    cmd_adr   = 32'h4000_0000;
    repeat (5) begin
      cycle();
      chk("bp_valid", 32'(rsp_valid_w[0]), 32'd1);
      chk("bp_err",   32'(rsp_err_w[0]),   32'd1);
      chk("bp_ready", 32'(cmd_ready_w[0]), 32'd0);
      chk("bp_stb",   32'(stb_w[1]),       32'd0);
    end
    stray_en = 1'b0;
    drain();

    // ack coincident with the timeout edge of instance 1
    rd_force = 32'hA5A5_0033;
    issue(1'b0, 4'hF, 32'h3000_0020, 32'h0, 2);
    repeat (3) cycle();
    chk("coinc_valid", 32'(rsp_valid_w[1]), 32'd1);
    chk("coinc_err",   32'(rsp_err_w[1]),   32'd0);
    chk("coinc_dat",   rsp_dat_w[1],        32'hA5A5_0033);
    drain();

    // reset in the middle of a bus cycle
    issue(1'b1, 4'hC, 32'h3000_0030, 32'h5555_AAAA, 100);
    cycle();
    #2;
    chk("mid_stb_before", 32'(stb_w[0]), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("mid_stb_async", 32'(stb_w[i]), 32'd0);
      chk("mid_cyc_async", 32'(cyc_w[i]), 32'd0);
    end
    cycle();
    #2 rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) begin
      cycle();
      chk("mid_no_rsp", 32'(rsp_valid_w[0] | rsp_valid_w[1]), 32'd0);
    end

    // randomized traffic
    dly_force = -1;
    stray_en  = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_we    = 1'($urandom_range(0, 1));
      cmd_sel   = 4'($urandom());
      cmd_adr   = $urandom();
      cmd_dat   = $urandom();
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        cycle();
        #2 rst = 1'b0;
      end
      cycle();
    end

    stray_en = 1'b0;
    drain();
    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
